// File: rtl/maze_motion_ctrl.sv
// Player-motion engine: pixel position, wall/bounds-checked turns at cell alignment, goal freeze.
// Optional MAZE_TURN_BUFFER_EN keeps direction taps made mid-cell for the next aligned step.
module maze_motion_ctrl #(
  parameter int GRID_W    = 10,
  parameter int GRID_H    = 15,
  parameter int CELL_LOG2 = 5,
  parameter int POS_W     = 9,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int GOAL_X    = 9,
  parameter int GOAL_Y    = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step,
  input  logic [3:0]                     btn,
  input  logic [GRID_W*(GRID_H+1)-1:0]   h_walls,
  input  logic [(GRID_W+1)*GRID_H-1:0]   v_walls,
  output logic [POS_W-1:0]               pos_x,
  output logic [POS_W-1:0]               pos_y,
  output logic [3:0]                     dir,
  output logic                           updated,
  output logic                           at_goal,
  output logic                           goal_pulse
);
  localparam int HW_N = GRID_W*(GRID_H+1);
  localparam int VW_N = (GRID_W+1)*GRID_H;
  localparam int HI_W = $clog2(HW_N);
  localparam int VI_W = $clog2(VW_N);
  localparam int C_W  = POS_W-CELL_LOG2;
  localparam logic [C_W-1:0]   XMAX     = C_W'(GRID_W-1);
  localparam logic [C_W-1:0]   YMAX     = C_W'(GRID_H-1);
  localparam logic [C_W-1:0]   GX       = C_W'(GOAL_X);
  localparam logic [C_W-1:0]   GY       = C_W'(GOAL_Y);
  localparam logic [POS_W-1:0] START_PX = POS_W'(START_X << CELL_LOG2);
  localparam logic [POS_W-1:0] START_PY = POS_W'(START_Y << CELL_LOG2);
  localparam bit               START_AT_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

  typedef enum logic {S_MOVE, S_FROZEN} state_t;

  state_t           state_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic [3:0]       dir_q, dir_d;
  logic             updated_q, at_goal_q, goal_pulse_q;
`ifdef MAZE_TURN_BUFFER_EN
  logic [3:0]       pending_q;
`endif

  logic [C_W-1:0]   cx, cy, ncx, ncy;
  logic             aligned, n_aligned, goal_hit;
  logic [VI_W-1:0]  idx_r, idx_l;
  logic [HI_W-1:0]  idx_d, idx_u;
  logic [3:0]       elig, req, cand, sel_dir;

  always_comb begin
    cx      = pos_x_q[POS_W-1:CELL_LOG2];
    cy      = pos_y_q[POS_W-1:CELL_LOG2];
    aligned = ~|pos_x_q[CELL_LOG2-1:0] & ~|pos_y_q[CELL_LOG2-1:0];
    idx_r   = VI_W'(cy)*VI_W'(GRID_W+1) + VI_W'(cx) + VI_W'(1);
    idx_l   = VI_W'(cy)*VI_W'(GRID_W+1) + VI_W'(cx);
    idx_d   = (HI_W'(cy) + HI_W'(1))*HI_W'(GRID_W) + HI_W'(cx);
    idx_u   = HI_W'(cy)*HI_W'(GRID_W) + HI_W'(cx);
    elig[0] = ~v_walls[idx_r] & (cx < XMAX);
    elig[1] = ~h_walls[idx_d] & (cy < YMAX);
    elig[2] = ~v_walls[idx_l] & (cx != '0);
    elig[3] = ~h_walls[idx_u] & (cy != '0);
`ifdef MAZE_TURN_BUFFER_EN
    req     = btn | pending_q;
`else
    req     = btn;
`endif
    cand    = req & elig;
    sel_dir = 4'b0000;
    if      (cand[0]) sel_dir = 4'b0001;
    else if (cand[1]) sel_dir = 4'b0010;
    else if (cand[2]) sel_dir = 4'b0100;
    else if (cand[3]) sel_dir = 4'b1000;
    // Turns are only taken on cell alignment; mid-cell the latched dir carries on.
    dir_d   = aligned ? sel_dir : dir_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (dir_d)
      4'b0001: pos_x_d = pos_x_q + POS_W'(1);
      4'b0010: pos_y_d = pos_y_q + POS_W'(1);
      4'b0100: pos_x_d = pos_x_q - POS_W'(1);
      4'b1000: pos_y_d = pos_y_q - POS_W'(1);
      default: ;
    endcase
    ncx       = pos_x_d[POS_W-1:CELL_LOG2];
    ncy       = pos_y_d[POS_W-1:CELL_LOG2];
    n_aligned = ~|pos_x_d[CELL_LOG2-1:0] & ~|pos_y_d[CELL_LOG2-1:0];
    goal_hit  = n_aligned && (ncx == GX) && (ncy == GY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= START_AT_GOAL ? S_FROZEN : S_MOVE;
      pos_x_q      <= START_PX;
      pos_y_q      <= START_PY;
      dir_q        <= 4'b0000;
      updated_q    <= 1'b0;
      at_goal_q    <= START_AT_GOAL;
      goal_pulse_q <= 1'b0;
`ifdef MAZE_TURN_BUFFER_EN
      pending_q    <= 4'b0000;
`endif
    end else begin
      updated_q    <= step;
      goal_pulse_q <= 1'b0;
      if (state_q == S_MOVE) begin
`ifdef MAZE_TURN_BUFFER_EN
        if (step && aligned) pending_q <= 4'b0000;
        else if (!aligned)   pending_q <= pending_q | btn;
`endif
        if (step) begin
          pos_x_q <= pos_x_d;
          pos_y_q <= pos_y_d;
          dir_q   <= dir_d;
          if (goal_hit) begin
            state_q      <= S_FROZEN;
            at_goal_q    <= 1'b1;
            goal_pulse_q <= 1'b1;
`ifdef MAZE_TURN_BUFFER_EN
            pending_q    <= 4'b0000;
`endif
          end
        end
      end
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign dir        = dir_q;
  assign updated    = updated_q;
  assign at_goal    = at_goal_q;
  assign goal_pulse = goal_pulse_q;
endmodule

// File: tb/tb_maze_motion_ctrl.sv
// Scoreboard bench for maze_motion_ctrl on a 4x3 grid of 4-px cells, start (1,1), goal (2,1).
module tb_maze_motion_ctrl;
  localparam int W = 4, H = 3, CL = 2, PW = 5, SX = 1, SY = 1, GX = 2, GY = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              step = 1'b0;
  logic [3:0]        btn = 4'b0000;
  logic [W*(H+1)-1:0] h_walls;
  logic [(W+1)*H-1:0] v_walls;
  logic [PW-1:0]     pos_x, pos_y;
  logic [3:0]        dir;
  logic              updated, at_goal, goal_pulse;

  always #5 clk = ~clk;

  maze_motion_ctrl #(.GRID_W(W), .GRID_H(H), .CELL_LOG2(CL), .POS_W(PW),
                     .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY)) dut (
    .clk(clk), .rst(rst), .step(step), .btn(btn), .h_walls(h_walls), .v_walls(v_walls),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .updated(updated), .at_goal(at_goal),
    .goal_pulse(goal_pulse));

  typedef struct { int px; int py; int d; int ag; int gp; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int mx, my, md, mgoal, mfroz;
  logic [3:0] mpend;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit can_go(input int cx, input int cy, input int d);
    case (d)
      0: return !v_walls[cy*(W+1)+cx+1] && (cx < W-1);
      1: return !h_walls[(cy+1)*W+cx] && (cy < H-1);
      2: return !v_walls[cy*(W+1)+cx] && (cx > 0);
      default: return !h_walls[cy*W+cx] && (cy > 0);
    endcase
  endfunction

  function automatic bit m_aligned();
    return ((mx % (1 << CL)) == 0) && ((my % (1 << CL)) == 0);
  endfunction

  task automatic do_reset();
    rst = 1'b1; step = 1'b0; btn = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mx = SX << CL; my = SY << CL; md = 0; mgoal = 0; mfroz = 0; mpend = 4'b0000;
  endtask

  // Called at a negedge; drives one step cycle and pushes the expected post-step outputs.
  task automatic do_step(input logic [3:0] b);
    logic [3:0] r;
    int gp = 0;
    if (!mfroz) begin
      if (m_aligned()) begin
`ifdef MAZE_TURN_BUFFER_EN
        r = b | mpend;
`else
        r = b;
`endif
        mpend = 4'b0000;
        md = 0;
        for (int i = 0; i < 4; i++)
          if (md == 0 && r[i] && can_go(mx >> CL, my >> CL, i)) md = 1 << i;
      end else begin
        mpend = mpend | b;
      end
      case (md)
        1: mx++;
        2: my++;
        4: mx--;
        8: my--;
        default: ;
      endcase
      if (m_aligned() && (mx >> CL) == GX && (my >> CL) == GY) begin
        mgoal = 1; mfroz = 1; gp = 1; mpend = 4'b0000;
      end
    end
    q.push_back('{mx, my, md, mgoal, gp});
    btn = b; step = 1'b1;
    @(negedge clk);
    step = 1'b0; btn = 4'b0000;
  endtask

  task automatic pulse_btn(input logic [3:0] b);
    if (!mfroz && !m_aligned()) mpend = mpend | b;
    btn = b;
    @(negedge clk);
    btn = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (goal_pulse) chk("gp_with_upd", int'(updated), 1);
      if (updated) begin
        chk("upd_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("sb_pos_x", int'(pos_x), e.px);
          chk("sb_pos_y", int'(pos_y), e.py);
          chk("sb_dir", int'(dir), e.d);
          chk("sb_at_goal", int'(at_goal), e.ag);
          chk("sb_goal_pulse", int'(goal_pulse), e.gp);
        end
      end
    end
  end

  initial begin
    h_walls = '0;
    v_walls = '0;
    for (int x = 0; x < W; x++) begin
      h_walls[x] = 1'b1;
      h_walls[H*W+x] = 1'b1;
    end
    for (int y = 0; y < H; y++) begin
      v_walls[y*(W+1)] = 1'b1;
      v_walls[y*(W+1)+W] = 1'b1;
    end

    // reset state
    do_reset();
    chk("rst_pos_x", int'(pos_x), 4);
    chk("rst_pos_y", int'(pos_y), 4);
    chk("rst_dir", int'(dir), 0);
    chk("rst_updated", int'(updated), 0);
    chk("rst_at_goal", int'(at_goal), 0);
    chk("rst_goal_pulse", int'(goal_pulse), 0);

    // right edge of (1,1) walled: right+down requested -> down
    v_walls[7] = 1'b1;
    do_step(4'b0011);
    repeat (2) @(negedge clk);
    chk("wall_dir", int'(dir), 2);
    chk("wall_pos_y", int'(pos_y), 5);
    chk("wall_pos_x", int'(pos_x), 4);
    repeat (3) do_step(4'b0000);
    repeat (2) @(negedge clk);
    chk("wall_arrive_y", int'(pos_y), 8);
    v_walls[7] = 1'b0;
    chk("wall_q_empty", q.size(), 0);

    // open run right into goal, then frozen
    do_reset();
    repeat (4) do_step(4'b0001);
    repeat (2) @(negedge clk);
    chk("goal_pos_x", int'(pos_x), 8);
    chk("goal_at_goal", int'(at_goal), 1);
    chk("goal_pulse_gone", int'(goal_pulse), 0);
    repeat (3) do_step(4'b0100);
    repeat (2) @(negedge clk);
    chk("frozen_pos_x", int'(pos_x), 8);
    chk("frozen_pos_y", int'(pos_y), 4);
    chk("frozen_q_empty", q.size(), 0);
    do_reset();
    chk("rerst_pos_x", int'(pos_x), 4);
    chk("rerst_at_goal", int'(at_goal), 0);

    // right border at (3,0) with its wall bit cleared: bounds rule stops
    v_walls[4] = 1'b0;
    repeat (4) do_step(4'b1000);
    repeat (8) do_step(4'b0001);
    repeat (3) do_step(4'b0001);
    repeat (2) @(negedge clk);
    chk("border_pos_x", int'(pos_x), 12);
    chk("border_pos_y", int'(pos_y), 0);
    chk("border_dir", int'(dir), 0);
    v_walls[4] = 1'b1;

    // down tap mid-cell while moving right along row 0
    do_reset();
    repeat (4) do_step(4'b1000);
    do_step(4'b0001);
    do_step(4'b0000);
    pulse_btn(4'b0010);
    do_step(4'b0000);
    do_step(4'b0000);
    do_step(4'b0000);
    repeat (2) @(negedge clk);
`ifdef MAZE_TURN_BUFFER_EN
    chk("buf_dir", int'(dir), 2);
    chk("buf_pos_y", int'(pos_y), 1);
`else
    chk("buf_dir", int'(dir), 0);
    chk("buf_pos_y", int'(pos_y), 0);
`endif
    chk("buf_pos_x", int'(pos_x), 8);
    chk("final_q_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
